// File: rtl/sumsq_feed_pkg.sv
// rtl/sumsq_feed_pkg.sv - shared defaults, state encoding and saturation helpers
package sumsq_feed_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int FBITS_DEF = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL_A = 3'd1,
    MUL_B = 3'd2,
    FINAL = 3'd3,
    HOLD  = 3'd4
  } state_t;

  // True when r does not fit in w unsigned bits.
  function automatic logic sat_ovf(input logic [63:0] r, input int unsigned w);
    return (r >> w) != 64'd0;
  endfunction

  // Clamp r to the largest w-bit unsigned value.
  function automatic logic [63:0] sat_clip(input logic [63:0] r, input int unsigned w);
    if (sat_ovf(r, w)) return (64'd1 << w) - 64'd1;
    return r;
  endfunction

endpackage

// File: rtl/sumsq_feed_if.sv
// rtl/sumsq_feed_if.sv - operand request, result and downstream root-unit handshake
interface sumsq_feed_if import sumsq_feed_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             valid;
  logic [WIDTH-1:0] sumsq;
  logic             ovf;
  logic [WIDTH-1:0] rad;
  logic             rad_start;
  logic             ds_busy;

  modport master (
    output start, a, b, ds_busy,
    input  busy, valid, sumsq, ovf, rad, rad_start
  );

  modport slave (
    input  start, a, b, ds_busy,
    output busy, valid, sumsq, ovf, rad, rad_start
  );
endinterface

// File: rtl/sumsq_feed_seq_square.sv
// rtl/sumsq_feed_seq_square.sv - WIDTH-cycle shift-add squarer, accumulator lives in the parent
module sumsq_feed_seq_square #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] addend,
  output logic               done
);
  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  // Load takes priority so the last step of one square can reload the next operand.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= {{WIDTH{1'b0}}, operand};
      mplier <= operand;
      cnt    <= '0;
    end else if (step) begin
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

  assign addend = mplier[0] ? mcand : '0;
  assign done   = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/sumsq_feed.sv
// rtl/sumsq_feed.sv - sequential a^2+b^2 with saturation, feeding the root unit
module sumsq_feed import sumsq_feed_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FBITS = FBITS_DEF
) (
  input  logic         clk,
  input  logic         rst,
  sumsq_feed_if.slave  bus
);
  localparam int ACC_W = 2 * WIDTH + 1;

  state_t             state;
  state_t             state_d;
  logic [ACC_W-1:0]   acc;
  logic [WIDTH-1:0]   b_lat;
  logic [WIDTH-1:0]   sumsq_q;
  logic               ovf_q;
  logic               valid_q;
  logic               rad_start_q;

  logic               sq_load;
  logic               sq_step;
  logic [WIDTH-1:0]   sq_operand;
  logic [2*WIDTH-1:0] sq_addend;
  logic               sq_done;
  logic               acc_clr;
  logic               acc_add;
  logic               fin;
  logic               issue;
  logic [63:0]        r_wide;

  sumsq_feed_seq_square #(.WIDTH(WIDTH)) u_square (
    .clk     (clk),
    .rst     (rst),
    .load    (sq_load),
    .step    (sq_step),
    .operand (sq_operand),
    .addend  (sq_addend),
    .done    (sq_done)
  );

  assign r_wide = 64'(acc >> FBITS);

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_d    = state;
    sq_load    = 1'b0;
    sq_step    = 1'b0;
    sq_operand = bus.a;
    acc_clr    = 1'b0;
    acc_add    = 1'b0;
    fin        = 1'b0;
    issue      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          sq_load = 1'b1;
          acc_clr = 1'b1;
          state_d = MUL_A;
        end
      end
      MUL_A: begin
        sq_step = 1'b1;
        acc_add = 1'b1;
        if (sq_done) begin
          sq_load    = 1'b1;
          sq_operand = b_lat;
          state_d    = MUL_B;
        end
      end
      MUL_B: begin
        sq_step = 1'b1;
        acc_add = 1'b1;
        if (sq_done) state_d = FINAL;
      end
      FINAL: begin
        fin = 1'b1;
        if (!bus.ds_busy) begin
          issue   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!bus.ds_busy) begin
          issue   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, accumulator and registered result/handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      b_lat       <= '0;
      sumsq_q     <= '0;
      ovf_q       <= 1'b0;
      valid_q     <= 1'b0;
      rad_start_q <= 1'b0;
    end else begin
      state       <= state_d;
      valid_q     <= fin;
      rad_start_q <= issue;
      if (acc_clr) begin
        acc   <= '0;
        b_lat <= bus.b;
      end else if (acc_add) begin
        acc <= acc + {1'b0, sq_addend};
      end
      if (fin) begin
        sumsq_q <= WIDTH'(sat_clip(r_wide, WIDTH));
        ovf_q   <= sat_ovf(r_wide, WIDTH);
      end
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.valid     = valid_q;
  assign bus.sumsq     = sumsq_q;
  assign bus.rad       = sumsq_q;
  assign bus.ovf       = ovf_q;
  assign bus.rad_start = rad_start_q;

endmodule

// File: tb/tb_sumsq_feed.sv
// tb/tb_sumsq_feed.sv - self-checking bench for sumsq_feed
module tb_sumsq_feed;
  localparam int W   = 16;
  localparam int F   = 8;
  localparam int LAT = 2 * W + 1;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  sumsq_feed_if #(.WIDTH(W)) bus();

  sumsq_feed #(.WIDTH(W), .FBITS(F)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: {ovf, sumsq} from plain integer arithmetic.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned sa, sb, s;
    logic [63:0] sv;
    sa = a;
    sb = b;
    s  = (sa * sa + sb * sb) >> F;
    if (s > ((64'd1 << W) - 64'd1)) return {1'b1, {W{1'b1}}};
    sv = s;
    return {1'b0, sv[W-1:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One operation with ds_busy low; caller sits at a negedge with the DUT idle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    logic [W:0] e;
    int k;
    e = model(a, b);
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    check({tag, "_quiet"}, 32'({bus.valid, bus.rad_start}), 32'd0);
    k = 0;
    while (k < LAT + 10 && bus.valid !== 1'b1) begin
      @(posedge clk); @(negedge clk);
      k++;
    end
    check({tag, "_latency"}, 32'(k), 32'(LAT));
    check({tag, "_sumsq"}, 32'(bus.sumsq), 32'(e[W-1:0]));
    check({tag, "_ovf"}, 32'(bus.ovf), 32'(e[W]));
    check({tag, "_rad"}, 32'(bus.rad), 32'(e[W-1:0]));
    check({tag, "_rad_start"}, 32'(bus.rad_start), 32'd1);
    check({tag, "_done_busy"}, 32'(bus.busy), 32'd0);
  endtask

  int               n_valid;
  int               n_rs;
  int               vk;
  int               rk;
  logic             busy35;
  logic             busy36;
  logic [W-1:0]     seen;
  logic [W-1:0]     ra;
  logic [W-1:0]     rb;

  initial begin
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.a       = '0;
    bus.b       = '0;
    bus.ds_busy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_flags", 32'({bus.busy, bus.valid, bus.rad_start, bus.ovf}), 32'd0);
    check("rst_sumsq", 32'(bus.sumsq), 32'd0);
    check("rst_rad", 32'(bus.rad), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(16'h0300, 16'h0400, "d_3_4");
    check("d_3_4_const", 32'(bus.sumsq), 32'h1900);
    run_op(16'h0080, 16'h0080, "d_half");
    check("d_half_const", 32'(bus.sumsq), 32'h0080);
    run_op(16'h0001, 16'h0001, "d_trunc");
    run_op(16'h1000, 16'h0000, "d_sat");
    check("d_sat_const", 32'({bus.ovf, bus.sumsq}), 32'h1FFFF);
    run_op(16'hFFFF, 16'hFFFF, "d_max");
    run_op(16'h0000, 16'h0000, "d_zero");

    for (int i = 0; i < 8; i++) begin
      if (i < 6) begin
        ra = W'($urandom_range(0, 16'h0B40));
        rb = W'($urandom_range(0, 16'h0B40));
      end else begin
        ra = W'($urandom);
        rb = W'($urandom);
      end
      run_op(ra, rb, $sformatf("rnd%0d", i));
    end

    // Downstream busy around FINAL, with stray start requests while busy.
    bus.a     = 16'h0F00;
    bus.b     = 16'h0400;
    bus.start = 1'b1;
    n_valid = 0; n_rs = 0; vk = -1; rk = -1; busy35 = 1'b0; busy36 = 1'b1; seen = '0;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); @(negedge clk);
      bus.start = 1'b0;
      if (bus.valid === 1'b1) begin n_valid++; vk = k; seen = bus.sumsq; end
      if (bus.rad_start === 1'b1) begin n_rs++; rk = k; end
      if (k == 35) busy35 = bus.busy;
      if (k == 36) busy36 = bus.busy;
      if (k == 30) bus.ds_busy = 1'b1;
      if (k == 35) bus.ds_busy = 1'b0;
      if (k == 5 || k == 20 || k == 34) begin
        bus.start = 1'b1;
        bus.a     = 16'hFFFF;
        bus.b     = 16'hFFFF;
      end
    end
    check("hold_valid_cnt", 32'(n_valid), 32'd1);
    check("hold_valid_cyc", 32'(vk), 32'(LAT));
    check("hold_sumsq", 32'(seen), 32'hF100);
    check("hold_rs_cnt", 32'(n_rs), 32'd1);
    check("hold_rs_cyc", 32'(rk), 32'd36);
    check("hold_busy35", 32'(busy35), 32'd1);
    check("hold_busy36", 32'(busy36), 32'd0);
    check("hold_idle_end", 32'(bus.busy), 32'd0);

    // Reset in the middle of an operation.
    bus.a     = 16'h1234;
    bus.b     = 16'h0567;
    bus.start = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    repeat (9) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("mid_rst_flags", 32'({bus.busy, bus.valid, bus.rad_start, bus.ovf}), 32'd0);
    check("mid_rst_sumsq", 32'(bus.sumsq), 32'd0);
    check("mid_rst_rad", 32'(bus.rad), 32'd0);
    rst = 1'b0;
    n_valid = 0;
    n_rs    = 0;
    repeat (40) begin
      @(posedge clk); @(negedge clk);
      if (bus.valid === 1'b1) n_valid++;
      if (bus.rad_start === 1'b1) n_rs++;
    end
    check("mid_rst_no_pulse", 32'(n_valid + n_rs), 32'd0);
    run_op(16'h0300, 16'h0400, "post_rst");
    check("post_rst_const", 32'(bus.sumsq), 32'h1900);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sumsq_feed.md
Name: sumsq_feed

Overview:
- Upstream feeder for the restoring fixed-point square-root unit.
- Accepts two unsigned fixed-point operands a and b and computes a² + b² in the same Q format using a sequential shift-add squarer.
- Saturates the result to WIDTH bits and presents it on rad with a one-cycle rad_start pulse, issued only when the downstream root unit is not busy.
- Together with the root unit this forms a vector-magnitude path: sqrt(a² + b²).

Parameters:
- WIDTH, 16, total operand/result width (unsigned fixed point).
- FBITS, 8, fractional bits (Q8.8 at defaults).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  operand A; latched on accepted start.
- b  input  WIDTH  operand B; latched on accepted start.
- busy  output  1  high from the cycle after an accepted start until rad_start has been issued.
- valid  output  1  one-cycle pulse; sumsq and ovf are valid.
- sumsq  output  WIDTH  saturated (a² + b²) >> FBITS; holds until the next result.
- ovf  output  1  result saturated; holds with sumsq.
- rad  output  WIDTH  radicand to the downstream root unit; same register as sumsq.
- rad_start  output  1  one-cycle start pulse to the downstream unit.
- ds_busy  input  1  downstream busy; rad_start is withheld while it is high.

Behaviour:
- Reset (rst=1 at an edge, including mid-operation):
  - state=IDLE.
  - busy, valid, rad_start, ovf = 0; sumsq/rad = 0.
  - Accumulator and counter cleared; any in-flight operation is discarded.
- States: IDLE, MUL_A, MUL_B, FINAL, HOLD.
- IDLE:
  - Edge with start=1: latch a and b, acc(2*WIDTH+1 bits)=0, cnt=0, go to MUL_A, busy=1.
  - start while busy=1 is ignored, with no side effects.
- MUL_A, one bit per edge, LSB first:
  - If mplier[0] is set, acc += mcand.
  - mcand <<= 1, mplier >>= 1.
  - After WIDTH edges (cnt=WIDTH-1), reload mcand/mplier from b, cnt=0, go to MUL_B.
- MUL_B: same procedure for b², WIDTH edges, then go to FINAL.
- FINAL (one edge):
  - r = acc >> FBITS (truncate, no rounding).
  - If r > 2^WIDTH - 1: sumsq = all ones, ovf=1; else sumsq = r[WIDTH-1:0], ovf=0.
  - valid=1 for exactly this one following cycle.
  - If ds_busy=0: rad_start=1, busy=0, go to IDLE.
  - Otherwise go to HOLD, busy stays 1.
- HOLD:
  - valid=0.
  - On the first edge with ds_busy=0: rad_start=1 for one cycle, busy=0, go to IDLE.
- Latency:
  - Start accepted at edge E0; valid high after edge E(2*WIDTH+1), i.e. E33 at defaults.
  - rad_start coincides with valid when ds_busy=0.
  - Back-to-back: a start in the first IDLE cycle is accepted, giving a throughput of 2*WIDTH+2 cycles.
- Other rules:
  - rad_start and valid are never high unless a result was just computed.
  - rad_start is never high while ds_busy was sampled high on the same edge.
  - Accumulator width 2*WIDTH+1 so that the sum cannot wrap before saturation.
- Zero operands follow the normal path; there is no early exit and latency is constant.

Decomposition:
- Shared package (fixed-point common):
  - WIDTH/FBITS defaults.
  - State enum (IDLE, MUL_A, MUL_B, FINAL, HOLD).
  - Saturation helper function.
- One natural sub-module: seq_square, a WIDTH-cycle shift-add squarer with load/step/done.
  - Instantiated once and reused for a then b.
  - The accumulator is shared in the parent.

Test Plan:
- a=0x0300 (3.0), b=0x0400 (4.0), ds_busy=0 -> valid and rad_start after E33; sumsq=rad=0x1900 (25.0), ovf=0.
- a=0x0080, b=0x0080 -> sumsq=0x0080 (0.5), ovf=0.
- a=0x0001, b=0x0001 -> sumsq=0x0000, ovf=0 (truncation check).
- a=0x1000 (16.0), b=0x0000 -> sumsq=0xFFFF, ovf=1.
- a=0x0F00, b=0x0400 with ds_busy high for 5 cycles around FINAL:
  - valid pulses once; sumsq=0xF100.
  - rad_start is delayed until the first edge with ds_busy=0; busy stays high until then.
  - Extra start pulses while busy are ignored.
- rst asserted at E10 of an operation:
  - All outputs are 0 at the next cycle; no valid or rad_start occurs.
  - A new start (a=0x0300, b=0x0400) after reset yields 0x1900.
